// File: rtl/dispatch_ctrl_pkg.sv
// Shared definitions for the dispatch stage: RV32 opcodes, dispatch classes, FSM states.
// The classify() helper is shared by the dispatcher and the decoder.
package dispatch_ctrl_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    CLS_RS  = 2'd0,
    CLS_LSB = 2'd1,
    CLS_ROB = 2'd2
  } disp_class_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_HOLD      = 2'd1,
    ST_WAIT_JALR = 2'd2
  } disp_state_e;

  // Opcodes the core does not implement still occupy a ROB slot so they can trap in order.
  function automatic disp_class_e classify(input logic [6:0] opc);
    disp_class_e cls;
    cls = CLS_ROB;
    case (opc)
      OPC_LOAD, OPC_STORE: cls = CLS_LSB;
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
      OPC_BRANCH, OPC_OP, OPC_OP_IMM: cls = CLS_RS;
      default: cls = CLS_ROB;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/dispatch_ctrl_if.sv
// Instruction-queue, backend-full and dispatch bus between the queue/backend and dispatch_ctrl.
// master = the dispatch controller, slave = the queue/backend side.
interface dispatch_ctrl_if #(
  parameter int XLEN = 32
);

  logic            iq_valid;
  logic [XLEN-1:0] iq_inst;
  logic [XLEN-1:0] iq_pc;
  logic            iq_ready;
  logic            rob_full;
  logic            rs_full;
  logic            lsb_full;
  logic [XLEN-1:0] dec_inst;
  logic [XLEN-1:0] dec_pc;
  logic            to_rob;
  logic            to_rs;
  logic            to_lsb;

  modport master (
    input  iq_valid, iq_inst, iq_pc, rob_full, rs_full, lsb_full,
    output iq_ready, dec_inst, dec_pc, to_rob, to_rs, to_lsb
  );

  modport slave (
    output iq_valid, iq_inst, iq_pc, rob_full, rs_full, lsb_full,
    input  iq_ready, dec_inst, dec_pc, to_rob, to_rs, to_lsb
  );

endinterface

// File: rtl/dispatch_ctrl_inst_classifier.sv
// Combinational opcode classifier: dispatch class plus JALR detect.
// Kept standalone so the decoder can reuse the same classification.
module inst_classifier
  import dispatch_ctrl_pkg::*;
(
  input  logic [6:0]  opcode,
  output disp_class_e cls,
  output logic        is_jalr
);

  always_comb begin
    cls     = classify(opcode);
    is_jalr = (opcode == OPC_JALR);
  end

endmodule

// File: rtl/dispatch_ctrl.sv
// Single-entry dispatch stage: holds one instruction, issues it when ROB and target unit
// accept, and serialises JALR by blocking the queue until the target resolves.
module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  dispatch_ctrl_if.master      bus,
  input  logic                 flush,
  input  logic                 jalr_done,
  input  logic [XLEN-1:0]      jalr_target,
  output logic                 fetch_redirect,
  output logic [XLEN-1:0]      fetch_pc,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     issue_cnt
);

  disp_state_e      state_q, state_d;
  logic [XLEN-1:0]  hold_inst_q, hold_inst_d;
  logic [XLEN-1:0]  hold_pc_q, hold_pc_d;
  logic             fetch_redirect_q, fetch_redirect_d;
  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;

  disp_class_e held_cls;
  logic        held_is_jalr;
  logic        unit_ok;
  logic        can_issue;
  logic        dispatch;
  logic        iq_ready_w;
  logic        pop;

  inst_classifier u_classifier (
    .opcode  (hold_inst_q[6:0]),
    .cls     (held_cls),
    .is_jalr (held_is_jalr)
  );

  // Reset gating keeps the handshake outputs quiet while the flops are being cleared.
  always_comb begin
    unit_ok = 1'b1;
    case (held_cls)
      CLS_RS:  unit_ok = !bus.rs_full;
      CLS_LSB: unit_ok = !bus.lsb_full;
      default: unit_ok = 1'b1;
    endcase
    can_issue  = (state_q == ST_HOLD) && !bus.rob_full && unit_ok;
    dispatch   = !rst_in && rdy_in && !flush && can_issue;
    iq_ready_w = !rst_in && rdy_in && !flush &&
                 ((state_q == ST_IDLE) || (dispatch && !held_is_jalr));
    pop        = iq_ready_w && bus.iq_valid;
  end

  assign bus.to_rob   = dispatch;
  assign bus.to_rs    = dispatch && (held_cls == CLS_RS);
  assign bus.to_lsb   = dispatch && (held_cls == CLS_LSB);
  assign bus.iq_ready = iq_ready_w;
  assign bus.dec_inst = hold_inst_q;
  assign bus.dec_pc   = hold_pc_q;

  assign fetch_redirect = fetch_redirect_q;
  assign fetch_pc       = fetch_pc_q;
  assign stall_cnt      = stall_cnt_q;
  assign issue_cnt      = issue_cnt_q;

  // Flush outranks everything, including a jalr_done arriving in the same cycle.
  always_comb begin
    state_d          = state_q;
    hold_inst_d      = hold_inst_q;
    hold_pc_d        = hold_pc_q;
    fetch_redirect_d = 1'b0;
    fetch_pc_d       = fetch_pc_q;
    stall_cnt_d      = stall_cnt_q;
    issue_cnt_d      = issue_cnt_q;

    if (rdy_in) begin
      if ((state_q == ST_HOLD) && !can_issue && !flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (dispatch) begin
        issue_cnt_d = issue_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end

      if (flush) begin
        state_d     = ST_IDLE;
        hold_inst_d = '0;
        hold_pc_d   = '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (pop) begin
              state_d     = ST_HOLD;
              hold_inst_d = bus.iq_inst;
              hold_pc_d   = bus.iq_pc;
            end
          end
          ST_HOLD: begin
            if (dispatch) begin
              if (held_is_jalr) begin
                state_d = ST_WAIT_JALR;
              end else if (pop) begin
                hold_inst_d = bus.iq_inst;
                hold_pc_d   = bus.iq_pc;
              end else begin
                state_d = ST_IDLE;
              end
            end
          end
          ST_WAIT_JALR: begin
            if (jalr_done) begin
              state_d          = ST_IDLE;
              fetch_redirect_d = 1'b1;
              fetch_pc_d       = jalr_target;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q          <= ST_IDLE;
      hold_inst_q      <= '0;
      hold_pc_q        <= '0;
      fetch_redirect_q <= 1'b0;
      fetch_pc_q       <= '0;
      stall_cnt_q      <= '0;
      issue_cnt_q      <= '0;
    end else begin
      state_q          <= state_d;
      hold_inst_q      <= hold_inst_d;
      hold_pc_q        <= hold_pc_d;
      fetch_redirect_q <= fetch_redirect_d;
      fetch_pc_q       <= fetch_pc_d;
      stall_cnt_q      <= stall_cnt_d;
      issue_cnt_q      <= issue_cnt_d;
    end
  end

endmodule
